load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-side counterpart of the single-cycle datapath's store/load outputs.
- Accepts one load or store per request: ALU result as byte address, rv2 as store data, funct3 as access size.
- Drives a word-wide data memory over a valid/ack handshake with variable latency. Stalls the core until completion.
- Returns aligned, sign/zero-extended load data for the register writeback mux.

Parameters:
- TIMEOUT, 255: max cycles to wait for mem_ack before flagging a bus error (8-bit counter; legal 1..255).
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents a memory op this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal.
- req_addr  in  ADDR_W  byte address (datapath aluout).
- req_wdata  in  32  store data (datapath memin).
- stall  out  1  core must hold its PC and request inputs.
- resp_valid  out  1  one-cycle pulse; op complete.
- resp_rdata  out  32  extended load data, valid with resp_valid on loads.
- resp_err  out  1  with resp_valid: misaligned, illegal funct3, or timeout.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  4  byte write enables; 0000 on loads.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits always 0.
- mem_wdata  out  32  store data replicated into the addressed lanes.
- mem_ack  in  1  memory completion; samples mem_rdata.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (async, rstn=0): state IDLE. stall, resp_valid, resp_err, mem_req all 0. mem_we=0, mem_addr=0, mem_wdata=0, resp_rdata=0, counter=0.
- States: IDLE, ACCESS, RESP.
- IDLE, req_valid=1, legal and aligned:
  - Register the request.
  - Go to ACCESS. stall=1 combinationally in the same cycle.
  - mem_req=1 from the next cycle.
- IDLE, req_valid=1, misaligned or illegal funct3:
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠00.
  - No memory access is issued.
  - Go to RESP with resp_err=1. stall=1 for that cycle.
- ACCESS: mem_req=1, outputs stable.
  - On mem_ack: latch the extended mem_rdata into resp_rdata, go to RESP.
  - If the counter reaches TIMEOUT without ack: drop mem_req, set resp_err=1, go to RESP.
  - An ack arriving in the same cycle the counter hits TIMEOUT counts as success.
- RESP: resp_valid=1 for exactly one cycle, stall=0, then IDLE.
  - The core advances on this edge. A new req_valid is not sampled until IDLE, so back-to-back ops have a 1-cycle bubble.
- Minimum latency, ack on the first ACCESS cycle: request cycle → ACCESS → RESP. That is 2 stall cycles.
- Store lanes, with off = addr[1:0]:
  - SB: mem_we = 0001<<off, wdata byte replicated 4×.
  - SH: mem_we = 0011<<off, halfword replicated 2×.
  - SW: mem_we = 1111.
- Load extract: byte = rdata[8*off+:8], half = rdata[16*off[1]+:16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Store responses: resp_rdata holds its previous value.
- mem_ack outside ACCESS is ignored.
- Reset mid-ACCESS: mem_req drops asynchronously. The in-flight op is abandoned with no response.

Decomposition:
- Shared package holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - LSU state encoding (IDLE=0, ACCESS=1, RESP=2).
- One natural sub-module, lsu_align: purely combinational.
  - Inputs funct3, off, wdata, rdata.
  - Outputs mem_we, lane-replicated wdata, extended rdata, misalign flag.
- FSM and timeout counter stay in load_store_unit.

Test Plan:
- SB addr=0x103, wdata=0x000000A5, ack after 1 cycle -> mem_addr=0x100, mem_we=1000, mem_wdata=0xA5A5A5A5, resp_valid after 2 stall cycles, resp_err=0.
- LB addr=0x201, mem_rdata=0x1234F600 -> resp_rdata=0xFFFFFFF6. LBU same -> 0x000000F6.
- LHU addr=0x302, mem_rdata=0x8001BEEF -> resp_rdata=0x00008001. LH same -> 0xFFFF8001.
- LW addr=0x405 -> no mem_req ever asserted, one-cycle resp_valid with resp_err=1.
- SW with mem_ack never asserted, TIMEOUT=4 -> mem_req high 4 cycles then low, resp_valid+resp_err, unit returns to IDLE and completes the next LW normally.
- rstn pulled low during ACCESS -> mem_req, stall immediately 0, no resp_valid. After release, req_valid LW addr=0x10, mem_rdata=0xDEADBEEF -> resp_rdata=0xDEADBEEF.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 access-size codes,
// FSM state encoding, the registered request record, and a legality helper.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // The memory word is split into byte lanes.
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } lsu_state_e;

  // The parts of an accepted request that are still needed after the
  // core's inputs are no longer looked at.
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
  } lsu_req_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide data-memory bus with a valid/ack handshake.
//   mem_req   : request, held until mem_ack
//   mem_we    : byte write enables (0000 on loads)
//   mem_addr  : word-aligned byte address
//   mem_wdata : store data, replicated into the addressed lanes
//   mem_ack   : completion; mem_rdata is sampled with it
//   mem_rdata : read word
// master = load/store unit, slave = memory.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational byte-lane steering for the load/store unit.
//   funct3     : access size / signedness code
//   off        : byte offset inside the word (addr[1:0])
//   wdata      : raw store data from the core
//   rdata      : raw word read from memory
//   mem_we     : lane write enables assuming a store
//   lane_wdata : store data replicated into every lane
//   ext_rdata  : load data extracted at off and sign/zero extended
//   misalign   : halfword on an odd byte, or word not on a word boundary
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]                       funct3,
  input  logic [1:0]                       off,
  input  logic [31:0]                      wdata,
  input  logic [31:0]                      rdata,
  output logic [NUM_LANES-1:0]             mem_we,
  output logic [NUM_LANES-1:0][LANE_W-1:0] lane_wdata,
  output logic [31:0]                      ext_rdata,
  output logic                             misalign
);

  logic        is_b, is_h, is_w;
  logic [7:0]  b_v;
  logic [15:0] h_v;

  // Size comes from funct3[1:0]; the unsigned bit only matters on loads.
  assign is_b = (funct3[1:0] == 2'b00);
  assign is_h = (funct3[1:0] == 2'b01);
  assign is_w = (funct3[1:0] == 2'b10);

  assign misalign = (is_h & off[0]) | (is_w & (off != 2'b00));

  // Each lane carries the store byte that would land there if the access
  // were placed at that lane, so the enables alone pick the real target.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    assign mem_we[i] = is_w | (is_h & (off[1] == LANE[1])) | (is_b & (off == LANE));
    assign lane_wdata[i] = is_b ? wdata[7:0] :
                           is_h ? wdata[8*(i%2) +: 8] :
                                  wdata[8*i +: 8];
  end

  assign b_v = rdata[{off, 3'b000} +: 8];
  assign h_v = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    ext_rdata = rdata;
    case (funct3)
      F3_B:    ext_rdata = {{24{b_v[7]}}, b_v};
      F3_BU:   ext_rdata = {24'd0, b_v};
      F3_H:    ext_rdata = {{16{h_v[15]}}, h_v};
      F3_HU:   ext_rdata = {16'd0, h_v};
      default: ext_rdata = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: takes one load/store per request from the core, runs it
// on the data-memory bus, stalls the core until done and returns extended
// load data for writeback.
//   clk, rstn          : clock, asynchronous active-low reset
//   req_valid/we/...   : core request (funct3 size, byte address, store data)
//   stall              : core holds PC and request while high
//   resp_valid         : one-cycle completion pulse
//   resp_rdata         : extended load data (held across stores/errors)
//   resp_err           : misaligned, illegal funct3 or ack timeout
//   bus                : memory bus (master side)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 255,  // ACCESS cycles allowed before giving up, 1..255
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  load_store_unit_if.master bus
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  lsu_state_e state, state_nxt;
  lsu_req_t   req_q;
  logic       err_q;
  logic [7:0] cnt, cnt_nxt;
  logic       req_ok, timeout;

  logic [2:0]                       al_f3;
  logic [1:0]                       al_off;
  logic [NUM_LANES-1:0]             al_we;
  logic [NUM_LANES-1:0][LANE_W-1:0] al_wdata;
  logic [31:0]                      al_rdata;
  logic                             al_mis;

  // One aligner serves both ends of the op: the live request while idle
  // (store lanes, misalign check) and the registered one while the access
  // is outstanding (load extraction).
  assign al_f3  = (state == S_IDLE) ? req_funct3    : req_q.funct3;
  assign al_off = (state == S_IDLE) ? req_addr[1:0] : req_q.off;

  lsu_align u_align (
    .funct3     (al_f3),
    .off        (al_off),
    .wdata      (req_wdata),
    .rdata      (bus.mem_rdata),
    .mem_we     (al_we),
    .lane_wdata (al_wdata),
    .ext_rdata  (al_rdata),
    .misalign   (al_mis)
  );

  assign req_ok  = f3_legal(req_funct3) && !al_mis;
  assign cnt_nxt = cnt + 8'd1;
  // cnt counts completed ACCESS cycles; this is the last one allowed.
  assign timeout = (cnt_nxt == TO_CNT);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; an ack on the final allowed cycle still wins.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = req_ok ? S_ACCESS : S_RESP;
      S_ACCESS: if (bus.mem_ack || timeout) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs. Stall is qualified with rstn so that a core still presenting
  // a request while reset is held sees no stall.
  always_comb begin
    stall       = 1'b0;
    resp_valid  = 1'b0;
    bus.mem_req = 1'b0;
    case (state)
      S_IDLE:   stall = req_valid & rstn;
      S_ACCESS: begin
        stall       = 1'b1;
        bus.mem_req = 1'b1;
      end
      S_RESP:   resp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign resp_err = resp_valid & err_q;

  // Request capture, timeout counter and response data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q         <= '0;
      err_q         <= 1'b0;
      cnt           <= '0;
      bus.mem_we    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      resp_rdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            err_q <= !req_ok;
            if (req_ok) begin
              req_q         <= '{we: req_we, funct3: req_funct3, off: req_addr[1:0]};
              bus.mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              bus.mem_we    <= req_we ? al_we : '0;
              bus.mem_wdata <= al_wdata;
            end
          end
        end
        S_ACCESS: begin
          cnt <= cnt_nxt;
          if (bus.mem_ack) begin
            err_q <= 1'b0;
            if (!req_q.we) resp_rdata <= al_rdata;
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TO = 4;

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    int        ack_at;     // ACCESS cycle on which memory acks, 0 = never
    bit        exp_err;
    int        exp_macc;   // cycles mem_req is expected high
    bit [3:0]  exp_we;
    bit [31:0] exp_wdata;
    bit [31:0] exp_rdata;  // only meaningful for successful loads
  } vec_t;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        stall, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit [31:0] last_rdata = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference: derived from access size and byte offset with plain arithmetic.
  function automatic vec_t model(input vec_t vi);
    vec_t v = vi;
    int size, off;
    bit legal;
    bit [31:0] mask, val, b;
    off   = int'(v.addr % 4);
    legal = (v.f3 == 0) || (v.f3 == 1) || (v.f3 == 2) || (v.f3 == 4) || (v.f3 == 5);
    size  = (v.f3 % 4 == 0) ? 1 : (v.f3 % 4 == 1) ? 2 : 4;
    v.exp_we = 4'd0; v.exp_wdata = 32'd0; v.exp_rdata = 32'd0;
    if (!legal || (off % size) != 0) begin
      v.exp_err = 1'b1; v.exp_macc = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        b = (v.wdata >> (8 * (i % size))) & 32'hFF;
        v.exp_wdata |= b << (8 * i);
      end
      if (v.we) v.exp_we = 4'(((1 << size) - 1) << off);
      if (v.ack_at == 0 || v.ack_at > TO) begin
        v.exp_err = 1'b1; v.exp_macc = TO;
      end else begin
        v.exp_err = 1'b0; v.exp_macc = v.ack_at;
      end
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      val  = (v.rdata >> (8 * off)) & mask;
      if (v.f3 < 4 && size < 4 && val[8*size-1]) val |= ~mask;
      v.exp_rdata = val;
    end
    return v;
  endfunction

  task automatic run_op(input vec_t v, input bit late_ack);
    int macc = 0, stl = 1;
    bit done = 1'b0;
    bit [31:0] exp_rd;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    bus.mem_rdata = v.rdata; bus.mem_ack = 1'b0;
    #1;
    chk("req_cycle_stall", stall, 1);
    chk("req_cycle_mem_req", bus.mem_req, 0);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk); #1;
      if (bus.mem_req) begin
        macc++;
        if (macc == 1) begin
          chk("mem_addr", bus.mem_addr, v.addr & 32'hFFFF_FFFC);
          chk("mem_we", {28'd0, bus.mem_we}, {28'd0, v.exp_we});
          if (v.we) chk("mem_wdata", bus.mem_wdata, v.exp_wdata);
        end
        bus.mem_ack = (macc == v.ack_at);
      end else begin
        bus.mem_ack = 1'b0;
      end
      if (resp_valid) begin
        done = 1'b1;
        exp_rd = (!v.we && !v.exp_err) ? v.exp_rdata : last_rdata;
        chk("resp_err", resp_err, v.exp_err);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_stall", stall, 0);
        last_rdata = exp_rd;
        req_valid = 1'b0;
        bus.mem_ack = late_ack;  // must be ignored outside ACCESS
      end else if (stall) begin
        stl++;
      end
    end
    chk("resp_seen", done, 1);
    chk("mem_req_cycles", macc, v.exp_macc);
    chk("stall_cycles", stl, v.exp_macc + 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("resp_one_cycle", resp_valid, 0);
    chk("idle_mem_req", bus.mem_req, 0);
  endtask

  vec_t tbl[15];
  vec_t v;
  logic [2:0] f3_tab [0:7];

  initial begin
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    //         we    f3    addr        wdata          rdata         ack err  macc we     exp_wdata      exp_rdata
    tbl[0]  = '{1'b1, 3'd0, 32'h103, 32'h0000_00A5, 32'h0,         1, 1'b0, 1, 4'h8, 32'hA5A5_A5A5, 32'h0};
    tbl[1]  = '{1'b0, 3'd0, 32'h201, 32'h0,         32'h1234_F600, 1, 1'b0, 1, 4'h0, 32'h0,         32'hFFFF_FFF6};
    tbl[2]  = '{1'b0, 3'd4, 32'h201, 32'h0,         32'h1234_F600, 2, 1'b0, 2, 4'h0, 32'h0,         32'h0000_00F6};
    tbl[3]  = '{1'b0, 3'd5, 32'h302, 32'h0,         32'h8001_BEEF, 1, 1'b0, 1, 4'h0, 32'h0,         32'h0000_8001};
    tbl[4]  = '{1'b0, 3'd1, 32'h302, 32'h0,         32'h8001_BEEF, 1, 1'b0, 1, 4'h0, 32'h0,         32'hFFFF_8001};
    tbl[5]  = '{1'b0, 3'd2, 32'h405, 32'h0,         32'h5555_5555, 1, 1'b1, 0, 4'h0, 32'h0,         32'h0};
    tbl[6]  = '{1'b1, 3'd2, 32'h500, 32'h1122_3344, 32'h0,         0, 1'b1, 4, 4'hF, 32'h1122_3344, 32'h0};
    tbl[7]  = '{1'b0, 3'd2, 32'h504, 32'h0,         32'hCAFE_F00D, 3, 1'b0, 3, 4'h0, 32'h0,         32'hCAFE_F00D};
    tbl[8]  = '{1'b0, 3'd2, 32'h508, 32'h0,         32'h0102_0304, 4, 1'b0, 4, 4'h0, 32'h0,         32'h0102_0304};
    tbl[9]  = '{1'b0, 3'd2, 32'h50C, 32'h0,         32'h0000_0099, 5, 1'b1, 4, 4'h0, 32'h0,         32'h0};
    tbl[10] = '{1'b1, 3'd1, 32'h602, 32'h1234_BEEF, 32'h0,         2, 1'b0, 2, 4'hC, 32'hBEEF_BEEF, 32'h0};
    tbl[11] = '{1'b0, 3'd3, 32'h700, 32'h0,         32'h0000_0001, 1, 1'b1, 0, 4'h0, 32'h0,         32'h0};
    tbl[12] = '{1'b0, 3'd1, 32'h701, 32'h0,         32'h0000_0001, 1, 1'b1, 0, 4'h0, 32'h0,         32'h0};
    tbl[13] = '{1'b1, 3'd0, 32'h800, 32'h0000_007F, 32'h0,         1, 1'b0, 1, 4'h1, 32'h7F7F_7F7F, 32'h0};
    tbl[14] = '{1'b0, 3'd0, 32'h903, 32'h0,         32'h80FF_FFFF, 1, 1'b0, 1, 4'h0, 32'h0,         32'hFFFF_FF80};

    // Reset state
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", {28'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    @(negedge clk); rstn = 1'b1;

    foreach (tbl[i]) run_op(tbl[i], 1'b0);

    // Reset while the access is outstanding: abandoned without a response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h20;
    bus.mem_ack = 1'b0;
    @(negedge clk); #1;
    chk("pre_rst_mem_req", bus.mem_req, 1);
    rstn = 1'b0; #1;
    chk("async_rst_mem_req", bus.mem_req, 0);
    chk("async_rst_stall", stall, 0);
    chk("async_rst_resp_valid", resp_valid, 0);
    req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      chk("in_rst_resp_valid", resp_valid, 0);
    end
    rstn = 1'b1; last_rdata = 32'd0;
    @(negedge clk); #1;
    chk("post_rst_resp_valid", resp_valid, 0);
    v = '{1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 1, 4'h0, 32'h0, 32'hDEAD_BEEF};
    run_op(v, 1'b0);

    // Randomized ops against the reference model
    for (int k = 0; k < 80; k++) begin
      int idx;
      idx = v.we ? 0 : 0;
      v.we = 1'($urandom_range(0, 1));
      idx = v.we ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) idx = int'($urandom_range(5, 7));
      v.f3 = f3_tab[idx];
      v.addr = $urandom;
      if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.ack_at = int'($urandom_range(0, 5));
      v = model(v);
      run_op(v, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
